// File: rtl/rvv_backend_dispatch_opcollect_pkg.sv
// rtl/rvv_backend_dispatch_opcollect_pkg.sv - shared types for the dispatch operand collector
package rvv_backend_dispatch_opcollect_pkg;

  localparam int VLEN = 128;

  // Bit order is {vd, vs2, vs1}, so the class value doubles as the operand need mask.
  typedef enum logic [2:0] {
    XXX = 3'b000,
    XXV = 3'b001,
    XVX = 3'b010,
    XVV = 3'b011,
    VXX = 3'b100,
    VVX = 3'b110,
    VVV = 3'b111
  } UOP_CLASS_e;

  typedef struct packed {
    logic [VLEN-1:0] v0;
    logic [VLEN-1:0] vs1;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] vd;
  } UOP_OPN_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } opc_state_e;

  function automatic logic [2:0] class_need(UOP_CLASS_e c);
    return 3'(c);
  endfunction

endpackage

// File: rtl/rvv_backend_dispatch_opcollect_alloc.sv
// rtl/rvv_backend_dispatch_opcollect_alloc.sv - maps pending operands onto VRF read ports
// RVV_OPCOLLECT_DUP_MERGE_EN: pending operands with equal indices share one port.
module rvv_backend_dispatch_opcollect_alloc #(
  parameter int NUM_RD_PORT = 2,
  parameter int VRF_AW      = 5
) (
  input  logic [2:0]                          pending,
  input  logic [VRF_AW-1:0]                   vs1_idx,
  input  logic [VRF_AW-1:0]                   vs2_idx,
  input  logic [VRF_AW-1:0]                   vd_idx,
  output logic [NUM_RD_PORT-1:0]              rd_en,
  output logic [NUM_RD_PORT-1:0][VRF_AW-1:0]  rd_index,
  output logic [NUM_RD_PORT-1:0]              sel_vs1,
  output logic [NUM_RD_PORT-1:0]              sel_vs2,
  output logic [NUM_RD_PORT-1:0]              sel_vd,
  output logic [2:0]                          served
);

`ifdef RVV_OPCOLLECT_DUP_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic       dup_vs2_vs1, dup_vd_vs1, dup_vd_vs2;
  logic [1:0] slot_vs1, slot_vs2, slot_vd, lead_cnt;

  // A duplicate rides on the slot of the earliest pending operand with the same index.
  assign dup_vs2_vs1 = MERGE && pending[0] && (vs2_idx == vs1_idx);
  assign dup_vd_vs1  = MERGE && pending[0] && (vd_idx == vs1_idx);
  assign dup_vd_vs2  = MERGE && pending[1] && (vd_idx == vs2_idx);

  always_comb begin
    slot_vs1 = 2'd0;
    lead_cnt = {1'b0, pending[0]};
    slot_vs2 = dup_vs2_vs1 ? slot_vs1 : lead_cnt;
    if (pending[1] && !dup_vs2_vs1) begin
      lead_cnt = lead_cnt + 2'd1;
    end
    if (dup_vd_vs1) begin
      slot_vd = slot_vs1;
    end else if (dup_vd_vs2) begin
      slot_vd = slot_vs2;
    end else begin
      slot_vd = lead_cnt;
    end

    served[0] = pending[0] && (int'(slot_vs1) < NUM_RD_PORT);
    served[1] = pending[1] && (int'(slot_vs2) < NUM_RD_PORT);
    served[2] = pending[2] && (int'(slot_vd) < NUM_RD_PORT);

    rd_en    = '0;
    rd_index = '0;
    sel_vs1  = '0;
    sel_vs2  = '0;
    sel_vd   = '0;
    for (int p = 0; p < NUM_RD_PORT; p++) begin
      sel_vs1[p] = served[0] && (slot_vs1 == 2'(p));
      sel_vs2[p] = served[1] && (slot_vs2 == 2'(p));
      sel_vd[p]  = served[2] && (slot_vd == 2'(p));
      if (sel_vs1[p]) begin
        rd_en[p]    = 1'b1;
        rd_index[p] = vs1_idx;
      end else if (sel_vs2[p]) begin
        rd_en[p]    = 1'b1;
        rd_index[p] = vs2_idx;
      end else if (sel_vd[p]) begin
        rd_en[p]    = 1'b1;
        rd_index[p] = vd_idx;
      end
    end
  end

endmodule

// File: rtl/rvv_backend_dispatch_opcollect.sv
// rtl/rvv_backend_dispatch_opcollect.sv - multi-cycle VRF operand collector for dispatch
// RVV_OPCOLLECT_DUP_MERGE_EN: enables shared reads for equal operand indices (in the alloc sub-module).
module rvv_backend_dispatch_opcollect
  import rvv_backend_dispatch_opcollect_pkg::*;
#(
  parameter int NUM_RD_PORT = 2,
  parameter int VRF_AW      = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 uop_valid,
  output logic                                 uop_ready,
  input  UOP_CLASS_e                           uop_class,
  input  logic [VRF_AW-1:0]                    uop_vs1_idx,
  input  logic [VRF_AW-1:0]                    uop_vs2_idx,
  input  logic [VRF_AW-1:0]                    uop_vd_idx,
  output logic [NUM_RD_PORT-1:0]               rd_en_dp2vrf,
  output logic [NUM_RD_PORT-1:0][VRF_AW-1:0]   rd_index_dp2vrf,
  input  logic [NUM_RD_PORT-1:0][VLEN-1:0]     rd_data_vrf2dp,
  input  logic [VLEN-1:0]                      v0_mask_vrf2dp,
  output logic                                 opn_valid,
  input  logic                                 opn_ready,
  output UOP_OPN_t                             opn
);

  opc_state_e              state;
  logic [2:0]              pending, alloc_pending, served, remaining;
  logic [VRF_AW-1:0]       vs1_idx, vs2_idx, vd_idx;
  logic [NUM_RD_PORT-1:0]  sel_vs1, sel_vs2, sel_vd;
  logic [VLEN-1:0]         data_vs1, data_vs2, data_vd;
  logic                    accept;

  assign uop_ready = !rst && !flush &&
                     ((state == IDLE) || ((state == DONE) && opn_ready));
  assign accept    = uop_valid && uop_ready;

  // Starving the allocator outside a live COLLECT cycle keeps the read ports quiet.
  assign alloc_pending = ((state == COLLECT) && !rst && !flush) ? pending : 3'b000;
  assign remaining     = pending & ~served;

  rvv_backend_dispatch_opcollect_alloc #(
    .NUM_RD_PORT (NUM_RD_PORT),
    .VRF_AW      (VRF_AW)
  ) u_alloc (
    .pending  (alloc_pending),
    .vs1_idx  (vs1_idx),
    .vs2_idx  (vs2_idx),
    .vd_idx   (vd_idx),
    .rd_en    (rd_en_dp2vrf),
    .rd_index (rd_index_dp2vrf),
    .sel_vs1  (sel_vs1),
    .sel_vs2  (sel_vs2),
    .sel_vd   (sel_vd),
    .served   (served)
  );

  always_comb begin
    data_vs1 = '0;
    data_vs2 = '0;
    data_vd  = '0;
    for (int p = 0; p < NUM_RD_PORT; p++) begin
      data_vs1 = data_vs1 | ({VLEN{sel_vs1[p]}} & rd_data_vrf2dp[p]);
      data_vs2 = data_vs2 | ({VLEN{sel_vs2[p]}} & rd_data_vrf2dp[p]);
      data_vd  = data_vd  | ({VLEN{sel_vd[p]}}  & rd_data_vrf2dp[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      vs1_idx   <= '0;
      vs2_idx   <= '0;
      vd_idx    <= '0;
      opn       <= '0;
      opn_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      pending   <= '0;
      opn       <= '0;
      opn_valid <= 1'b0;
    end else if (accept) begin
      // Clearing the buffer on accept is what makes unneeded fields read as zero.
      state     <= COLLECT;
      pending   <= class_need(uop_class);
      vs1_idx   <= uop_vs1_idx;
      vs2_idx   <= uop_vs2_idx;
      vd_idx    <= uop_vd_idx;
      opn       <= '0;
      opn_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (served[0]) opn.vs1 <= data_vs1;
          if (served[1]) opn.vs2 <= data_vs2;
          if (served[2]) opn.vd  <= data_vd;
          opn.v0  <= v0_mask_vrf2dp;
          pending <= remaining;
          if (remaining == 3'b000) begin
            state     <= DONE;
            opn_valid <= 1'b1;
          end
        end
        DONE: begin
          if (opn_ready) begin
            state     <= IDLE;
            opn_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rvv_backend_dispatch_opcollect.md
Name: rvv_backend_dispatch_opcollect

Overview:
- Requester side of the dispatch VRF read interface. Takes one uop at a time and works out which vector operands it needs (vs1, vs2, vd) from its uop class.
- Issues read indices to the VRF over NUM_RD_PORT ports across as many cycles as needed, captures the returned data into an operand buffer, then presents a complete UOP_OPN_t to the issue stage with a valid/ready handshake.
- Sits between the uop queue and the reservation-station issue logic. It replaces static port-to-operand wiring when the read port count is smaller than the operand count.

Parameters:
- NUM_RD_PORT, 2, number of VRF read ports owned by this block (1..3).
- VRF_AW, 5, VRF register index width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous pipeline flush; drops the in-flight uop.
- uop_valid  input  1  uop offered.
- uop_ready  output  1  block accepts uop this cycle.
- uop_class  input  UOP_CLASS_e  operand need encoding {vd,vs2,vs1}: XXX, XXV, XVX, VXX, XVV, VVX, VVV.
- uop_vs1_idx / uop_vs2_idx / uop_vd_idx  input  VRF_AW each  operand indices.
- rd_en_dp2vrf  output  NUM_RD_PORT  per-port read enable.
- rd_index_dp2vrf  output  NUM_RD_PORT x VRF_AW  per-port read index.
- rd_data_vrf2dp  input  NUM_RD_PORT x VLEN  read data, combinational same cycle as index.
- v0_mask_vrf2dp  input  VLEN  v0 mask.
- opn_valid  output  1  operand bundle valid.
- opn_ready  input  1  consumer accepts bundle.
- opn  output  UOP_OPN_t  {v0, vs1, vs2, vd}.

Behaviour:
- FSM states: IDLE, COLLECT, DONE.
- uop_ready = (state==IDLE) || (state==DONE && opn_ready). Accepting a uop latches class and indices, sets the pending mask {vd,vs2,vs1} from the class, and moves to COLLECT.
- COLLECT, each cycle:
  - Assign pending operands to ports in priority vs1, vs2, vd; lowest pending goes to port 0. At most NUM_RD_PORT are assigned.
  - Unused ports drive rd_en=0 and index 0.
  - At the clock edge, captured data goes into the buffer fields, the served bits clear, and v0 is captured from v0_mask_vrf2dp.
  - When the pending mask becomes 0, go to DONE.
  - XXX: exactly one COLLECT cycle with all rd_en=0; v0 only.
- DONE: opn_valid=1 and opn is held stable until opn_ready.
  - opn_ready && uop_valid: back-to-back accept, go to COLLECT.
  - opn_ready only: go to IDLE.
- Latency, accept at edge T, NUM_RD_PORT=2: 0–2 operands give opn_valid from T+2; 3 operands give T+3. NUM_RD_PORT=1: needed reads +1.
- Operand fields not needed by the class read 0.
- flush: wins over all else. Go to IDLE, clear pending, opn_valid=0; a uop offered in the flush cycle is not accepted (uop_ready=0).
- Reset values:
  - state IDLE.
  - uop_ready=1 after the reset cycle (0 while rst is high).
  - opn_valid=0, opn=0.
  - rd_en_dp2vrf=0, rd_index_dp2vrf=0.
- opn_valid low with opn_ready high is legal and has no effect.

Optional Feature:
- RVV_OPCOLLECT_DUP_MERGE_EN.
- Defined: pending operands with equal indices (e.g. vs1==vs2) share one port. The captured data fans out to every matching field, and all matching pending bits clear together. VVV with vs1==vs2==vd completes in a single COLLECT cycle.
- Undefined: every needed operand consumes its own port slot regardless of index equality.

Decomposition:
- UOP_CLASS_e, UOP_OPN_t, VLEN and the collector state enum belong in the shared package (rvv_backend.svh / rvv_backend_dispatch.svh).
- One sub-module is natural: rvv_backend_dispatch_opcollect_alloc. It is combinational and maps pending mask + indices to port enables/indices and per-field capture selects; DUP_MERGE lives there.

Test Plan:
- NUM_RD_PORT=2, VVV, vs1=3, vs2=4, vd=5, opn_ready=1:
  - cycle T+1: ports read {3,4};
  - cycle T+2: port0 reads 5;
  - opn_valid at T+3 with correct vs1/vs2/vd data.
- XVX, vs2=7: a single read of 7 on port0 at T+1; opn_valid at T+2 with vs1=vd=0, and v0 equals the mask driven at T+1.
- Back-to-back uops:
  - opn_ready held 0 for 3 cycles, so opn stays stable and uop_ready=0;
  - then opn_ready=1 with uop_valid=1, so the next uop is accepted in the same cycle with no bubble.
- flush asserted in the second COLLECT cycle of a VVV: next cycle is IDLE, opn_valid never rises, and rd_en=0.
- rst asserted while in DONE: next cycle opn_valid=0, all outputs 0, then uop_ready=1.
- With RVV_OPCOLLECT_DUP_MERGE_EN, VVV with vs1=vs2=vd=9: one cycle on one port at index 9, opn_valid at T+2 with all three fields equal. Without the macro, opn_valid is at T+3.
